// File: rtl/uart_led_cmd.sv
// Command front-end for the breathing-LED stage: parses A5/CMD/ARG/SUM frames
// from the UART receiver, drives en (optionally timed) and returns a status byte.
module uart_led_cmd #(
  parameter int unsigned FREQUENCE = 75_000_000,
  parameter int unsigned TIMEOUT   = 750_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       en,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       resp_lost
);

  localparam int unsigned PW = (FREQUENCE > 1) ? $clog2(FREQUENCE) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam logic [7:0] RESP_OK  = 8'h5A;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ARG  = 3'd2,
    S_SUM  = 3'd3,
    S_EXEC = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic          in_frame_c, cap_cmd_c, cap_arg_c, cap_sum_c, exec_c, timeout_c;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    cmd_q, arg_q;
  logic          sum_ok_q;

  logic          mode_timed;
  logic [7:0]    sec_cnt;
  logic [PW-1:0] presc;

  logic [7:0]    resp_c;
  logic          set_off_c, set_on_c, set_timed_c;

  // Idle gap inside a frame has run out; a byte arriving on that edge still counts
  assign timeout_c = in_frame_c && !rx_valid && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (rx_valid && rx_data == SYNC) state_nxt = S_CMD;
      S_CMD:  if (rx_valid) state_nxt = S_ARG; else if (timeout_c) state_nxt = S_IDLE;
      S_ARG:  if (rx_valid) state_nxt = S_SUM; else if (timeout_c) state_nxt = S_IDLE;
      S_SUM:  if (rx_valid) state_nxt = S_EXEC; else if (timeout_c) state_nxt = S_IDLE;
      S_EXEC: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_frame_c = 1'b0;
    cap_cmd_c  = 1'b0;
    cap_arg_c  = 1'b0;
    cap_sum_c  = 1'b0;
    exec_c     = 1'b0;
    case (state)
      S_CMD:  begin in_frame_c = 1'b1; cap_cmd_c = rx_valid; end
      S_ARG:  begin in_frame_c = 1'b1; cap_arg_c = rx_valid; end
      S_SUM:  begin in_frame_c = 1'b1; cap_sum_c = rx_valid; end
      S_EXEC: exec_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !in_frame_c || rx_valid || timeout_c) idle_cnt <= '0;
    else                                            idle_cnt <= idle_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= '0;
      arg_q    <= '0;
      sum_ok_q <= 1'b0;
    end else begin
      if (cap_cmd_c) cmd_q <= rx_data;
      if (cap_arg_c) arg_q <= rx_data;
      if (cap_sum_c) sum_ok_q <= (rx_data == (cmd_q ^ arg_q));
    end
  end

  // Command decode; only acted on while in EXEC
  always_comb begin
    resp_c      = RESP_ERR;
    set_off_c   = 1'b0;
    set_on_c    = 1'b0;
    set_timed_c = 1'b0;
    if (sum_ok_q) begin
      case (cmd_q)
        8'h00: begin set_off_c = 1'b1; resp_c = RESP_OK; end
        8'h01: begin set_on_c = 1'b1; resp_c = RESP_OK; end
        8'h02: begin
          if (arg_q != 8'h00) set_timed_c = 1'b1;
          else                set_off_c   = 1'b1;
          resp_c = RESP_OK;
        end
        8'h03: resp_c = mode_timed ? sec_cnt : (en ? 8'hFF : 8'h00);
        default: resp_c = RESP_ERR;
      endcase
    end
  end

  // Enable / seconds timer; a state-changing command overrides a same-cycle expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      en         <= 1'b0;
      mode_timed <= 1'b0;
      sec_cnt    <= '0;
      presc      <= '0;
    end else if (exec_c && set_off_c) begin
      en         <= 1'b0;
      mode_timed <= 1'b0;
      sec_cnt    <= '0;
      presc      <= '0;
    end else if (exec_c && set_on_c) begin
      en         <= 1'b1;
      mode_timed <= 1'b0;
      sec_cnt    <= '0;
      presc      <= '0;
    end else if (exec_c && set_timed_c) begin
      en         <= 1'b1;
      mode_timed <= 1'b1;
      sec_cnt    <= arg_q;
      presc      <= '0;
    end else if (mode_timed) begin
      if (presc == PW'(FREQUENCE - 1)) begin
        presc <= '0;
        if (sec_cnt == 8'd1) begin
          sec_cnt    <= '0;
          en         <= 1'b0;
          mode_timed <= 1'b0;
        end else begin
          sec_cnt <= sec_cnt - 8'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end else begin
      presc <= '0;
    end
  end

  // Response holding register toward the transmitter
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      resp_lost <= 1'b0;
    end else begin
      resp_lost <= 1'b0;
      if (exec_c) begin
        tx_data   <= resp_c;
        tx_valid  <= 1'b1;
        resp_lost <= tx_valid && !tx_ready;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_led_cmd.sv
// Randomised bench for uart_led_cmd against a frame/queue-level reference model.
module tb_uart_led_cmd;

  localparam int unsigned F  = 100;
  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       resp_lost;

  always #5 clk = ~clk;

  uart_led_cmd #(.FREQUENCE(F), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .en(en), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .resp_lost(resp_lost)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame bytes collected in a queue, timer as cycles remaining
  logic [7:0] q[$];
  int         age;
  bit         pend;
  bit         m_en, m_timed;
  int         rem;
  bit         m_txv, m_lost;
  logic [7:0] m_txd;
  int         cyc = 0;
  int         lost_cnt = 0;
  bit         rand_rdy = 0;

  task automatic model_reset();
    q.delete();
    age = 0; pend = 0;
    m_en = 0; m_timed = 0; rem = 0;
    m_txv = 0; m_lost = 0; m_txd = 8'h00;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit rdy);
    logic [7:0] resp;
    bit load, chg, n_en, n_timed;
    int n_rem;
    load = 0; chg = 0; resp = 8'hEE;
    n_en = m_en; n_timed = m_timed; n_rem = rem;
    if (pend) begin
      load = 1;
      if (q[3] == (q[1] ^ q[2])) begin
        if (q[1] == 8'h00 || (q[1] == 8'h02 && q[2] == 8'h00)) begin
          chg = 1; n_en = 0; n_timed = 0; n_rem = 0; resp = 8'h5A;
        end else if (q[1] == 8'h01) begin
          chg = 1; n_en = 1; n_timed = 0; n_rem = 0; resp = 8'h5A;
        end else if (q[1] == 8'h02) begin
          chg = 1; n_en = 1; n_timed = 1; n_rem = int'(q[2]) * F; resp = 8'h5A;
        end else if (q[1] == 8'h03) begin
          resp = m_timed ? 8'((rem + F - 1) / F) : (m_en ? 8'hFF : 8'h00);
        end
      end
    end
    if (chg) begin
      m_en = n_en; m_timed = n_timed; rem = n_rem;
    end else if (m_timed) begin
      rem--;
      if (rem == 0) begin m_en = 0; m_timed = 0; end
    end
    m_lost = 0;
    if (load) begin
      m_lost = m_txv && !rdy;
      m_txv = 1;
      m_txd = resp;
    end else if (m_txv && rdy) begin
      m_txv = 0;
    end
    if (pend) begin
      pend = 0;
      q.delete();
    end else if (q.size() == 0) begin
      if (v && d == 8'hA5) begin q.push_back(d); age = 0; end
    end else if (v) begin
      q.push_back(d);
      age = 0;
      if (q.size() == 4) pend = 1;
    end else begin
      age++;
      if (age == TO) q.delete();
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] d);
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(v, d, tx_ready);
    cyc++;
    #1;
    if (resp_lost) lost_cnt++;
    check("en", en, m_en);
    check("tx_valid", tx_valid, m_txv);
    check("tx_data", tx_data, m_txd);
    check("resp_lost", resp_lost, m_lost);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
    tick(1, 8'hA5);
    tick(1, c);
    tick(1, a);
    tick(1, s);
    tick(0, 8'h00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [7:0] c, a, s, j;
    rst = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    idle(2);
    rst = 1'b0;
    check("rst_en", en, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 8'h00);

    // Reset mid-frame, then a clean on command
    tick(1, 8'hA5); tick(1, 8'h01);
    rst = 1'b1; idle(2); rst = 1'b0;
    check("midrst_en", en, 0);
    check("midrst_txv", tx_valid, 0);
    check("midrst_lost", resp_lost, 0);
    send_frame(8'h01, 8'h00, 8'h01);
    check("on_en", en, 1);
    check("on_txd", tx_data, 8'h5A);
    send_frame(8'h00, 8'h00, 8'h00);
    check("off_en", en, 0);

    // Timed on for 3 s with a query part-way
    send_frame(8'h02, 8'h03, 8'h01);
    t0 = cyc;
    check("timed_en", en, 1);
    idle(145);
    send_frame(8'h03, 8'h00, 8'h03);
    check("query_timed", tx_data, 8'h02);
    while (en && (cyc - t0) < 400) tick(0, 8'h00);
    check("timed_len", ((cyc - t0) >= 299 && (cyc - t0) <= 301), 1);
    check("timed_off", en, 0);

    // Bad checksum and unknown command
    send_frame(8'h01, 8'h00, 8'h00);
    check("badsum_txd", tx_data, 8'hEE);
    check("badsum_en", en, 0);
    send_frame(8'h07, 8'h00, 8'h07);
    check("unknown_txd", tx_data, 8'hEE);

    // Inter-byte timeout drops the frame
    tick(1, 8'hA5); tick(1, 8'h01);
    idle(25);
    tick(1, 8'h00); tick(1, 8'h01);
    idle(2);
    check("timeout_txv", tx_valid, 0);
    check("timeout_en", en, 0);
    send_frame(8'h01, 8'h00, 8'h01);
    check("after_to_en", en, 1);
    check("after_to_txd", tx_data, 8'h5A);

    // Handshake back-pressure and overwrite
    idle(1);
    tx_ready = 1'b0;
    lost_cnt = 0;
    send_frame(8'h03, 8'h00, 8'h03);
    check("hs_first", tx_data, 8'hFF);
    send_frame(8'h00, 8'h00, 8'h00);
    check("hs_lost_cnt", lost_cnt, 1);
    check("hs_txd", tx_data, 8'h5A);
    check("hs_txv_held", tx_valid, 1);
    tx_ready = 1'b1;
    tick(0, 8'h00);
    check("hs_txv_drop", tx_valid, 0);

    // Untimed command overrides a running timer
    send_frame(8'h02, 8'h05, 8'h07);
    t0 = cyc;
    idle(200);
    send_frame(8'h01, 8'h00, 8'h01);
    while ((cyc - t0) < 550) tick(0, 8'h00);
    check("ovr_en", en, 1);
    send_frame(8'h03, 8'h00, 8'h03);
    check("ovr_query", tx_data, 8'hFF);
    send_frame(8'h00, 8'h00, 8'h00);
    check("ovr_off", en, 0);

    // Random frames, gaps, junk, back-pressure and one reset
    rand_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      if (n == 30) begin rst = 1'b1; tick(0, 8'h00); rst = 1'b0; end
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom_range(0, 255));
        tick(1, (j == 8'hA5) ? 8'h00 : j);
      end
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'h02;
        3: c = 8'h03;
        4: c = 8'h04;
        default: c = 8'h07;
      endcase
      a = (c == 8'h02) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
      s = c ^ a;
      if ($urandom_range(0, 7) == 0) s = s ^ 8'h01;
      tick(1, 8'hA5);
      idle(($urandom_range(0, 9) == 0) ? 22 : $urandom_range(0, 2));
      tick(1, c);
      idle($urandom_range(0, 2));
      tick(1, a);
      idle($urandom_range(0, 2));
      tick(1, s);
      idle($urandom_range(1, 60));
    end
    rand_rdy = 0;
    tx_ready = 1'b1;
    idle(250);
    check("final_txv", tx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_led_cmd.md
# uart_led_cmd

Command front-end for the breathing-LED stage. It takes bytes from the UART receiver, parses fixed 4-byte command frames and drives the `en` input of the breathing-LED block. Each frame can switch `en` on, off, or on for a timed number of seconds. Every valid or failed frame gets a one-byte status response on a valid/ready port toward the UART transmitter.

## Interface
Parameters:
- FREQUENCE, 75_000_000, clk cycles per second (seconds prescaler)
- TIMEOUT, 750_000, max idle clk cycles between bytes of one frame

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- en  out  1  enable to breathing-LED stage
- tx_valid  out  1  response byte pending
- tx_data  out  8  response byte
- tx_ready  in  1  transmitter accepts tx_data when high with tx_valid
- resp_lost  out  1  one-cycle pulse: pending response overwritten

## Operation
- Frame: 0xA5, CMD, ARG, SUM; valid iff SUM == CMD ^ ARG.
- FSM states: IDLE, CMD, ARG, SUM, EXEC.
  - IDLE: bytes other than 0xA5 are ignored; 0xA5 -> CMD.
  - CMD: byte stored -> ARG.
  - ARG: byte stored -> SUM.
  - SUM: byte compared -> EXEC.
  - EXEC: lasts one cycle; applies the command and loads the response -> IDLE.
  - rx_valid is ignored while in EXEC.
- Inter-byte timeout:
  - In CMD/ARG/SUM, an idle counter is cleared on every rx_valid.
  - When the counter reaches TIMEOUT, the frame is abandoned -> IDLE. No response, no state change.
- A 0xA5 received in CMD/ARG/SUM is treated as data, not a resync.
- Commands on a valid frame:
  - 0x00: en=0, timer cleared. Response 0x5A.
  - 0x01: en=1, untimed. Response 0x5A.
  - 0x02: ARG!=0 -> en=1, sec_cnt=ARG, prescaler cleared. ARG==0 behaves as 0x00. Response 0x5A.
  - 0x03 query: no state change. Response is sec_cnt if timed-on, 0xFF if untimed-on, 0x00 if off.
  - Other CMD: no state change. Response 0xEE.
- Bad checksum: no state change, response 0xEE.
- Timer:
  - While timed-on, the prescaler counts 0..FREQUENCE-1.
  - At wrap, sec_cnt decrements.
  - When a wrap occurs with sec_cnt==1: sec_cnt=0, en=0, mode off.
  - Untimed-on and off hold the prescaler at 0.
- Timer expiry in the same cycle as EXEC: EXEC wins.
- Response register:
  - Loading sets tx_valid=1.
  - tx_valid clears on the cycle after tx_valid&tx_ready is sampled.
  - If EXEC loads while tx_valid=1 and tx_ready=0: new byte replaces old and resp_lost pulses for that cycle.
  - If tx_ready=1 in that same cycle: old byte counts as accepted, new byte loads, no resp_lost.
- tx_data is held stable while tx_valid=1 unless overwritten as above.

## Timing
- Reset values: en=0, tx_valid=0, tx_data=0x00, resp_lost=0; FSM IDLE, sec_cnt=0, prescaler=0, idle counter=0.
- rst has priority over every other input, including mid-frame and mid-timer.
- Latency: SUM byte sampled at edge N; EXEC during cycle N..N+1; en, tx_valid and tx_data updated at edge N+1 (visible the cycle after the SUM strobe cycle).
- Back-to-back frames: 0xA5 may arrive the cycle after EXEC.
- Timed-on duration: en falls ARG*FREQUENCE cycles (±1) after the EXEC edge.
- Timeout: the frame is dropped on the edge where the idle count equals TIMEOUT after the last accepted byte.

## Test plan
Bench settings: FREQUENCE=100, TIMEOUT=20.

- Reset: assert rst 2 cycles mid-frame (after A5,01) -> all outputs 0. Then full frame A5,01,00,01 -> en=1, tx_data=0x5A.
- Timed on: frame A5,02,03,01 -> en=1 for 300±1 cycles then 0. Query A5,03,00,03 sent at ~150 cycles -> tx_data=0x02.
- Bad frame: A5,01,00,00 -> tx_data=0xEE, en unchanged. Unknown command A5,07,00,07 -> 0xEE.
- Timeout: A5,01, then 25 idle cycles, then 00,01 -> no response, en=0. Next full frame is accepted.
- Handshake: hold tx_ready=0 and send two valid frames -> resp_lost pulses once, tx_data shows the second response. Raise tx_ready -> tx_valid drops the next cycle.
- Override: timed-on ARG=5, then 0x01 mid-count -> en stays 1 past 500 cycles, query returns 0xFF. Then 0x00 -> en=0 at latency 1.
